// File: rtl/ahblite_key_ctrl_pkg.sv
// Shared definitions for the AHB-lite key controller: register offsets and CTRL layout.
package key_pkg;

    // Word offsets decoded from HADDR[4:2]
    localparam logic [2:0] KEY_DATA  = 3'd0;
    localparam logic [2:0] KEY_RAW   = 3'd1;
    localparam logic [2:0] KEY_STAT  = 3'd2;
    localparam logic [2:0] KEY_IRQEN = 3'd3;
    localparam logic [2:0] KEY_CTRL  = 3'd4;

    // CTRL bit positions
    localparam int CTRL_INVERT_BIT      = 0;
    localparam int CTRL_RELEASE_EVT_BIT = 1;

    // CTRL register image; first member is the MSB so invert lands on bit 0
    typedef struct packed {
        logic release_evt;
        logic invert;
    } ctrl_t;

endpackage

// File: rtl/ahblite_key_ctrl_if.sv
// AHB-lite bus bundle between a master (bench or interconnect) and the key controller slave.
interface ahblite_key_ctrl_if;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HTRANS, HSIZE, HPROT, HWRITE, HADDR, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HTRANS, HSIZE, HPROT, HWRITE, HADDR, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahblite_key_ctrl_debounce.sv
// One key channel: 2-flop synchroniser, polarity correction, debounce counter and
// accepted-edge pulses. The pulses are combinational and coincide with the edge that
// updates the stable level.
module key_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    input  logic invert,
    output logic sync,
    output logic stable,
    output logic rise,
    output logic fall
);
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          meta_q, meta_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Synchroniser flops reset to 0, so their output is not meaningful until two
    // edges after reset; counting is held off until then to avoid a false accept
    // when invert=1 and the pins idle high.
    logic [1:0]    warm_q, warm_d;
    logic          accept;

    // Next-state: synchroniser shift, debounce counter, stable level update
    always_comb begin
        meta_d   = key_raw;
        sync2_d  = meta_q;
        warm_d   = {warm_q[0], 1'b1};
        sync     = sync2_q ^ invert;
        accept   = 1'b0;
        stable_d = stable_q;
        cnt_d    = '0;
        if (warm_q[1] && (sync != stable_q)) begin
            if (cnt_q == CNT_MAX) begin
                accept   = 1'b1;
                stable_d = sync;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        rise   = accept & sync;
        fall   = accept & ~sync;
        stable = stable_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q   <= 1'b0;
            sync2_q  <= 1'b0;
            warm_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= meta_d;
            sync2_q  <= sync2_d;
            warm_q   <= warm_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/ahblite_key_ctrl.sv
// AHB-lite key controller: address decode, register file, press/release event flags
// and the level interrupt. Per-key debouncing lives in key_debounce.
module ahblite_key_ctrl
    import key_pkg::*;
#(
    parameter int NKEY        = 4,
    parameter int DEB_CYCLES  = 500000,
    parameter int ACT_LOW_DEF = 1
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahblite_key_ctrl_if.slave   bus,
    input  logic [NKEY-1:0]     key_data,
    output logic                key_irq
);
    logic [NKEY-1:0] sync_vec, stable_vec, rise_vec, fall_vec, evt_vec;

    logic            ph_write_q, ph_write_d;
    logic            ph_read_q, ph_read_d;
    logic [2:0]      ph_addr_q, ph_addr_d;
    logic [NKEY-1:0] stat_q, stat_d;
    logic [NKEY-1:0] irqen_q, irqen_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic            irq_q, irq_d;
    logic            addr_accept;

    // Bus bits this slave does not decode
    logic unused_bus;
    assign unused_bus = ^{bus.HSIZE, bus.HPROT, bus.HTRANS[0], bus.HADDR[31:5],
                          bus.HADDR[1:0], bus.HWDATA};

    for (genvar i = 0; i < NKEY; i++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk     (HCLK),
            .rst_n   (HRESETn),
            .key_raw (key_data[i]),
            .invert  (ctrl_q.invert),
            .sync    (sync_vec[i]),
            .stable  (stable_vec[i]),
            .rise    (rise_vec[i]),
            .fall    (fall_vec[i])
        );
    end

    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;
    assign key_irq       = irq_q;

    // Next-state: address-phase capture, register writes, event flags, interrupt
    always_comb begin
        addr_accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
        ph_write_d  = addr_accept & bus.HWRITE;
        ph_read_d   = addr_accept & ~bus.HWRITE;
        ph_addr_d   = addr_accept ? bus.HADDR[4:2] : 3'd0;

        evt_vec = rise_vec | (fall_vec & {NKEY{ctrl_q.release_evt}});

        irqen_d = irqen_q;
        ctrl_d  = ctrl_q;
        stat_d  = stat_q;
        if (ph_write_q) begin
            case (ph_addr_q)
                KEY_STAT:  stat_d  = stat_q & ~bus.HWDATA[NKEY-1:0];
                KEY_IRQEN: irqen_d = bus.HWDATA[NKEY-1:0];
                KEY_CTRL:  ctrl_d  = ctrl_t'(bus.HWDATA[1:0]);
                default: ;
            endcase
        end
        // A new event overrides a simultaneous write-1-to-clear
        stat_d = stat_d | evt_vec;

        irq_d = |(stat_q & irqen_q);
    end

    // Read mux: driven only during the data phase of a read transfer
    always_comb begin
        bus.HRDATA = 32'h0;
        if (ph_read_q) begin
            case (ph_addr_q)
                KEY_DATA:  bus.HRDATA = 32'(stable_vec);
                KEY_RAW:   bus.HRDATA = 32'(sync_vec);
                KEY_STAT:  bus.HRDATA = 32'(stat_q);
                KEY_IRQEN: bus.HRDATA = 32'(irqen_q);
                KEY_CTRL:  bus.HRDATA = 32'(ctrl_q);
                default:   bus.HRDATA = 32'h0;
            endcase
        end
    end

    // Register file and bus pipeline with synchronous active-low reset
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            ph_write_q         <= 1'b0;
            ph_read_q          <= 1'b0;
            ph_addr_q          <= 3'd0;
            stat_q             <= '0;
            irqen_q            <= '0;
            ctrl_q.invert      <= (ACT_LOW_DEF != 0);
            ctrl_q.release_evt <= 1'b0;
            irq_q              <= 1'b0;
        end else begin
            ph_write_q <= ph_write_d;
            ph_read_q  <= ph_read_d;
            ph_addr_q  <= ph_addr_d;
            stat_q     <= stat_d;
            irqen_q    <= irqen_d;
            ctrl_q     <= ctrl_d;
            irq_q      <= irq_d;
        end
    end
endmodule

// File: tb/tb_ahblite_key_ctrl.sv
// Directed bench for ahblite_key_ctrl with NKEY=4, DEB_CYCLES=4, ACT_LOW_DEF=1.
module tb_ahblite_key_ctrl;
    logic        HCLK;
    logic        HRESETn;
    logic [3:0]  key_data;
    logic        key_irq;
    logic [31:0] rd;
    int          n_checks;
    int          n_fail;

    ahblite_key_ctrl_if bus ();

    ahblite_key_ctrl #(
        .NKEY        (4),
        .DEB_CYCLES  (4),
        .ACT_LOW_DEF (1)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .bus      (bus),
        .key_data (key_data),
        .key_irq  (key_irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 32'h0;
    endtask

    task automatic ahb_read(input logic [2:0] off, output logic [31:0] data);
        @(negedge HCLK);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b0;
        bus.HADDR  = {27'd0, off, 2'b00};
        @(posedge HCLK);
        @(negedge HCLK);
        data = bus.HRDATA;
        idle_bus();
    endtask

    task automatic ahb_write(input logic [2:0] off, input logic [31:0] wd);
        @(negedge HCLK);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1;
        bus.HADDR  = {27'd0, off, 2'b00};
        @(posedge HCLK);
        @(negedge HCLK);
        idle_bus();
        bus.HWDATA = wd;
        @(posedge HCLK);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        HRESETn     = 1'b0;
        key_data    = 4'hF;
        bus.HSIZE   = 3'b010;
        bus.HPROT   = 4'b0011;
        bus.HREADY  = 1'b1;
        bus.HWDATA  = 32'h0;
        idle_bus();
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Reset state
        check("reset_irq", {31'd0, key_irq}, 32'h0);
        check("reset_hrdata", bus.HRDATA, 32'h0);
        check("hreadyout", {31'd0, bus.HREADYOUT}, 32'h1);
        check("hresp", {31'd0, bus.HRESP}, 32'h0);
        ahb_read(3'd0, rd); check("reset_data", rd, 32'h0);
        ahb_read(3'd4, rd); check("reset_ctrl", rd, 32'h1);
        ahb_read(3'd1, rd); check("reset_raw", rd, 32'h0);
        ahb_read(3'd2, rd); check("reset_stat", rd, 32'h0);

        // Reset during the data phase of an IRQEN write discards the write
        @(negedge HCLK);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1;
        bus.HADDR  = 32'hC;
        @(posedge HCLK);
        @(negedge HCLK);
        idle_bus();
        bus.HWDATA = 32'hF;
        HRESETn    = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        ahb_read(3'd3, rd); check("midreset_irqen", rd, 32'h0);
        ahb_read(3'd4, rd); check("midreset_ctrl", rd, 32'h1);

        // Press key 2, back-to-back DATA reads watch the exact acceptance edge
        @(negedge HCLK);
        key_data[2] = 1'b0;
        bus.HSEL    = 1'b1;
        bus.HTRANS  = 2'b10;
        bus.HWRITE  = 1'b0;
        bus.HADDR   = 32'h0;
        for (int k = 0; k < 6; k++) begin
            @(posedge HCLK);
            @(negedge HCLK);
            check($sformatf("latency_edge%0d", k + 1), bus.HRDATA, (k == 5) ? 32'h4 : 32'h0);
        end
        idle_bus();
        repeat (4) @(negedge HCLK);
        ahb_read(3'd2, rd); check("press_stat", rd, 32'h4);
        ahb_read(3'd1, rd); check("press_raw", rd, 32'h4);

        // Three-cycle glitch on key 1 is rejected
        @(negedge HCLK);
        key_data[1] = 1'b0;
        repeat (3) @(negedge HCLK);
        key_data[1] = 1'b1;
        repeat (10) @(negedge HCLK);
        ahb_read(3'd0, rd); check("glitch_data", rd, 32'h4);
        ahb_read(3'd2, rd); check("glitch_stat", rd, 32'h4);

        // Interrupt enable; upper written bits are not stored
        ahb_write(3'd3, 32'hFFFF_FFF4);
        @(negedge HCLK); check("irq_same_edge", {31'd0, key_irq}, 32'h0);
        @(negedge HCLK); check("irq_next_edge", {31'd0, key_irq}, 32'h1);
        ahb_read(3'd3, rd); check("irqen_mask", rd, 32'h4);
        ahb_write(3'd2, 32'h4);
        @(negedge HCLK); check("irq_hold", {31'd0, key_irq}, 32'h1);
        @(negedge HCLK); check("irq_cleared", {31'd0, key_irq}, 32'h0);
        ahb_read(3'd2, rd); check("stat_w1c", rd, 32'h0);

        // Clear STAT[0] on the same edge key 0's press is accepted
        @(negedge HCLK);
        key_data[0] = 1'b0;
        repeat (4) @(posedge HCLK);
        ahb_write(3'd2, 32'h1);
        @(negedge HCLK);
        ahb_read(3'd2, rd); check("set_wins_stat", rd, 32'h1);
        ahb_read(3'd0, rd); check("set_wins_data", rd, 32'h5);

        // Release events enabled, release key 2
        ahb_write(3'd4, 32'h3);
        ahb_read(3'd4, rd); check("ctrl_rw", rd, 32'h3);
        ahb_write(3'd2, 32'hF);
        ahb_read(3'd2, rd); check("stat_clear_all", rd, 32'h0);
        @(negedge HCLK);
        key_data[2] = 1'b1;
        repeat (10) @(negedge HCLK);
        ahb_read(3'd0, rd); check("release_data", rd, 32'h1);
        ahb_read(3'd2, rd); check("release_stat", rd, 32'h4);
        @(negedge HCLK); check("release_irq", {31'd0, key_irq}, 32'h1);
        ahb_read(3'd6, rd); check("offset6_read", rd, 32'h0);
        ahb_write(3'd5, 32'hFFFF_FFFF);
        ahb_read(3'd3, rd); check("offset5_no_irqen", rd, 32'h4);
        ahb_read(3'd4, rd); check("offset5_no_ctrl", rd, 32'h3);

        // Dropping invert re-debounces every key with the new polarity
        ahb_write(3'd2, 32'hF);
        ahb_write(3'd4, 32'h2);
        repeat (10) @(negedge HCLK);
        ahb_read(3'd0, rd); check("invert_data", rd, 32'hE);
        ahb_read(3'd1, rd); check("invert_raw", rd, 32'hE);
        ahb_read(3'd2, rd); check("invert_stat", rd, 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
